// File: rtl/cursor_ctrl.sv
// cursor_ctrl: converts debounced push-button levels into a wrapped two-axis
// BCD cursor position for the life grid editor.
// position = {y_ones, y_tens, x_ones, x_tens}; moved pulses the cycle after a step.
// Optional feature macro: CURSOR_AUTOREPEAT_EN (auto-repeat while a button is held).
module cursor_ctrl #(
  parameter int          X_MAX        = 23,
  parameter int          Y_MAX        = 31,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  output logic [15:0] position,
  output logic        moved
);

  // Maximum values split into {tens, ones} BCD digits.
  localparam logic [7:0] X_MAX_BCD = {4'(X_MAX / 10), 4'(X_MAX % 10)};
  localparam logic [7:0] Y_MAX_BCD = {4'(Y_MAX / 10), 4'(Y_MAX % 10)};

  // Parameter sanity: two BCD digits per axis, and a repeat period that fits
  // inside the initial delay so the counter reload value is non-negative.
  if (X_MAX < 0 || X_MAX > 99 || Y_MAX < 0 || Y_MAX > 99) begin : g_bad_max
    $error("cursor_ctrl: X_MAX/Y_MAX must be within 0..99");
  end
  if (REPEAT_RATE == 0 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
    $error("cursor_ctrl: REPEAT_RATE must be in 1..REPEAT_DELAY");
  end

  // Two-digit BCD increment with wrap from max back to 00.
  function automatic logic [7:0] bcd_up(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit BCD decrement with wrap from 00 to max.
  function automatic logic [7:0] bcd_down(input logic [7:0] v, input logic [7:0] maxv);
    if (v == 8'h00)
      return maxv;
    else if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [3:0] btn_q;
  logic [7:0] x_bcd;     // {tens, ones}
  logic [7:0] y_bcd;     // {tens, ones}
  logic       step_p0;   // a step happened on the previous edge

  logic [3:0] press_ev;
  logic [3:0] step_req;
  logic       x_up, x_dn, y_up, y_dn;
  logic [7:0] x_next, y_next;

`ifdef CURSOR_AUTOREPEAT_EN
  logic [31:0] hold_cnt;
  logic        hold_clr;
  logic        repeat_hit;

  // Hold counter restarts on any change of the button pattern or when idle.
  always_comb begin
    hold_clr   = (btn != btn_q) || (btn == 4'd0);
    repeat_hit = !hold_clr && ((hold_cnt + 32'd1) == REPEAT_DELAY);
  end

  // Hold counter: reaching REPEAT_DELAY fires a repeat and rewinds by one period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_cnt <= 32'd0;
    else if (hold_clr)
      hold_cnt <= 32'd0;
    else if (repeat_hit)
      hold_cnt <= REPEAT_DELAY - REPEAT_RATE;
    else
      hold_cnt <= hold_cnt + 32'd1;
  end
`else
  logic repeat_hit;

  // Edge-only build: holding a button never generates further steps.
  always_comb begin
    repeat_hit = 1'b0;
  end
`endif

  // Step request decode; an opposing pair on one axis cancels.
  always_comb begin
    press_ev = btn & ~btn_q;
    step_req = press_ev | (repeat_hit ? btn : 4'd0);
    x_up     = step_req[0] & ~step_req[1];
    x_dn     = step_req[1] & ~step_req[0];
    y_up     = step_req[2] & ~step_req[3];
    y_dn     = step_req[3] & ~step_req[2];
    x_next   = x_bcd;
    y_next   = y_bcd;
    if (x_up)
      x_next = bcd_up(x_bcd, X_MAX_BCD);
    else if (x_dn)
      x_next = bcd_down(x_bcd, X_MAX_BCD);
    if (y_up)
      y_next = bcd_up(y_bcd, Y_MAX_BCD);
    else if (y_dn)
      y_next = bcd_down(y_bcd, Y_MAX_BCD);
  end

  // Stage p0: button history, cursor position and step flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= 4'd0;
      x_bcd   <= 8'h00;
      y_bcd   <= 8'h00;
      step_p0 <= 1'b0;
    end else begin
      btn_q   <= btn;
      x_bcd   <= x_next;
      y_bcd   <= y_next;
      step_p0 <= x_up | x_dn | y_up | y_dn;
    end
  end

  // Stage p1: moved pulse lands in the cycle after the position change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      moved <= 1'b0;
    else
      moved <= step_p0;
  end

  // Output digit order is {y_ones, y_tens, x_ones, x_tens}.
  always_comb begin
    position = {y_bcd[3:0], y_bcd[7:4], x_bcd[3:0], x_bcd[7:4]};
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed testbench for cursor_ctrl (REPEAT_DELAY=10, REPEAT_RATE=4).
module tb_cursor_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn = 4'd0;
  logic [15:0] position;
  logic        moved;
  int          checks = 0;
  int          errors = 0;
  int          moved_cnt = 0;

  cursor_ctrl #(
    .X_MAX(23), .Y_MAX(31), .REPEAT_DELAY(10), .REPEAT_RATE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .position(position), .moved(moved)
  );

  always #5 clk = ~clk;

  // Count moved pulses, sampled away from the active edge.
  always @(negedge clk) if (moved) moved_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected position from decimal coordinates.
  function automatic logic [15:0] pos_of(input int x, input int y);
    return {4'(y % 10), 4'(y / 10), 4'(x % 10), 4'(x / 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press for one cycle, then release for one cycle.
  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'd0;
    tick();
  endtask

  task automatic do_reset();
    btn = 4'd0;
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_pos", 32'(position), 32'h0000);
    chk("rst_moved", 32'(moved), 32'd0);
    rst_n = 1'b1;
    tick();

    // X+1 walk through wrap
    moved_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      btn = 4'b0001;
      tick();
      chk($sformatf("walk_x%0d", i), 32'(position), 32'(pos_of(i % 24, 0)));
      btn = 4'd0;
      tick();
      if (i == 1) chk("walk_moved_hi", 32'(moved), 32'd1);
    end
    tick();
    chk("walk_moved_cnt", 32'(moved_cnt), 32'd24);

    // Y down wrap then up wrap
    press(4'b1000);
    chk("y_down_wrap", 32'(position), 32'h1300);
    press(4'b0100);
    chk("y_up_wrap", 32'(position), 32'h0000);

    // X down wrap from 0
    press(4'b0010);
    chk("x_down_wrap", 32'(position), 32'h0032);
    press(4'b0001);
    chk("x_up_to_0", 32'(position), 32'h0000);

    // Borrow and opposing-pair cancel
    for (int i = 0; i < 10; i++) press(4'b0001);
    chk("x_10", 32'(position), 32'h0001);
    press(4'b0010);
    chk("x_borrow", 32'(position), 32'h0090);
    tick();
    btn = 4'b0011;
    tick();
    chk("cancel_pos", 32'(position), 32'h0090);
    btn = 4'd0;
    tick();
    chk("cancel_moved", 32'(moved), 32'd0);

    // Simultaneous X+1 and Y+1
    do_reset();
    moved_cnt = 0;
    btn = 4'b0101;
    tick();
    chk("xy_pos", 32'(position), 32'h1010);
    btn = 4'd0;
    tick();
    tick();
    tick();
    chk("xy_moved_cnt", 32'(moved_cnt), 32'd1);

    // Hold X+1 for 30 cycles
    do_reset();
    btn = 4'b0001;
    for (int i = 0; i < 30; i++) tick();
    btn = 4'd0;
    tick();
`ifdef CURSOR_AUTOREPEAT_EN
    chk("hold_x", 32'(position), 32'(pos_of(6, 0)));
`else
    chk("hold_x", 32'(position), 32'(pos_of(1, 0)));
`endif

    // Async reset during a hold, release with button still held
    do_reset();
    btn = 4'b0001;
    tick();
    tick();
    chk("pre_rst_x", 32'(position), 32'(pos_of(1, 0)));
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_pos", 32'(position), 32'h0000);
    tick();
    chk("rst_hold_pos", 32'(position), 32'h0000);
    rst_n = 1'b1;
    tick();
    chk("rel_step", 32'(position), 32'(pos_of(1, 0)));
    for (int i = 0; i < 5; i++) tick();
    chk("rel_one_step", 32'(position), 32'(pos_of(1, 0)));
    btn = 4'd0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
